// File: rtl/lock_pkg.sv
// Shared definitions for the lock keypad logic: key codes, the digit test
// and the state encoding of the code-entry sequencer.
package lock_pkg;

  localparam logic [3:0] KEY_STAR = 4'b1010;
  localparam logic [3:0] KEY_HASH = 4'b1011;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_EVAL    = 3'd2,
    S_NEW_A   = 3'd3,
    S_NEW_B   = 3'd4,
    S_LOCKOUT = 3'd5
  } entry_state_t;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'd9;
  endfunction

endpackage

// File: rtl/digit_buffer.sv
// Entry buffer: nibble shift register with a count that saturates one past
// full and a sticky overflow flag; clear together with shift_en loads a digit.
module digit_buffer #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset_1,
  input  logic                clear,
  input  logic                shift_en,
  input  logic [3:0]          digit,
  output logic [4*DIGITS-1:0] code,
  output logic [2:0]          cnt,
  output logic                overflow
);

  localparam logic [2:0] FULL = 3'(DIGITS);
  localparam logic [2:0] OVER = 3'(DIGITS + 1);

  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      code     <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      code     <= shift_en ? {{(4*DIGITS-4){1'b0}}, digit} : '0;
      cnt      <= shift_en ? 3'd1 : 3'd0;
      overflow <= 1'b0;
    end else if (shift_en) begin
      // Once full, further digits only mark the entry as too long.
      if (cnt >= FULL) begin
        cnt      <= OVER;
        overflow <= 1'b1;
      end else begin
        code <= {code[4*DIGITS-5:0], digit};
        cnt  <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/code_entry_ctrl.sv
// Keypad entry sequencer: assembles digit entries, judges them against the
// stored password, runs the two-entry password change and the fail lockout.
module code_entry_ctrl
  import lock_pkg::*;
#(
  parameter int unsigned         DIGITS      = 4,
  parameter int unsigned         TIMEOUT_CYC = 1000,
  parameter int unsigned         MAX_FAIL    = 3,
  parameter int unsigned         LOCKOUT_CYC = 5000,
  parameter logic [4*DIGITS-1:0] DEFAULT_PW  = 16'h1234
) (
  input  logic                clk,
  input  logic                reset_1,
  input  logic [3:0]          key_code,
  input  logic                key_valid,
  output logic [4*DIGITS-1:0] code_word,
  output logic [2:0]          digit_cnt,
  output logic                open_pulse,
  output logic                fail_pulse,
  output logic                lockout,
  output logic                change_mode,
  output logic                pw_changed,
  output logic                err_pulse,
  output logic                timeout_pulse
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int LW = $clog2(LOCKOUT_CYC);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCKOUT_CYC - 1);
  localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAIL);
  localparam logic [2:0]    FULL_CNT   = 3'(DIGITS);

  entry_state_t        state;
  logic [4*DIGITS-1:0] pw, cand, buf_code;
  logic [2:0]          buf_cnt;
  logic                buf_ovf, buf_clear, buf_shift;
  logic [TW-1:0]       timer;
  logic [LW-1:0]       lock_cnt;
  logic [FW-1:0]       fail_cnt, fail_inc;
  logic                term_hash;
  logic                key_digit, key_hash, key_star, key_accept;
  logic                in_entry, in_change, timer_exp, count_ok;

  assign key_digit  = key_valid && is_digit(key_code);
  assign key_hash   = key_valid && (key_code == KEY_HASH);
  assign key_star   = key_valid && (key_code == KEY_STAR);
  assign key_accept = key_digit || key_hash || key_star;
  assign in_change  = (state == S_NEW_A) || (state == S_NEW_B);
  assign in_entry   = (state == S_COLLECT) || in_change;
  // A key landing on the expiry cycle wins over the timeout.
  assign timer_exp  = in_entry && !key_accept && (timer == TIMER_LAST);
  assign count_ok   = (buf_cnt == FULL_CNT) && !buf_ovf;
  assign fail_inc   = (fail_cnt == FAIL_MAX) ? fail_cnt : fail_cnt + FW'(1);

  assign buf_shift = key_digit && ((state == S_IDLE) || in_entry);
  assign buf_clear = (state == S_IDLE && key_digit) || (state == S_EVAL) || timer_exp ||
                     (in_change && (key_hash || key_star));

  digit_buffer #(.DIGITS(DIGITS)) u_digit_buffer (
    .clk      (clk),
    .reset_1  (reset_1),
    .clear    (buf_clear),
    .shift_en (buf_shift),
    .digit    (key_code),
    .code     (buf_code),
    .cnt      (buf_cnt),
    .overflow (buf_ovf)
  );

  assign code_word = buf_code;
  assign digit_cnt = buf_cnt;

  always_ff @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      state         <= S_IDLE;
      pw            <= DEFAULT_PW;
      cand          <= '0;
      timer         <= '0;
      lock_cnt      <= '0;
      fail_cnt      <= '0;
      term_hash     <= 1'b0;
      open_pulse    <= 1'b0;
      fail_pulse    <= 1'b0;
      lockout       <= 1'b0;
      change_mode   <= 1'b0;
      pw_changed    <= 1'b0;
      err_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every decision below sees the
      // pre-edge register values regardless of statement order.
      open_pulse    <= 1'b0;
      fail_pulse    <= 1'b0;
      pw_changed    <= 1'b0;
      err_pulse     <= 1'b0;
      timeout_pulse <= 1'b0;
      if (in_entry) timer <= (key_accept || timer_exp) ? '0 : timer + TW'(1);

      case (state)
        S_IDLE: if (key_digit) begin
          state <= S_COLLECT;
          timer <= '0;
        end
        S_COLLECT: begin
          if (key_hash || key_star) begin
            term_hash <= key_hash;
            state     <= S_EVAL;
          end else if (timer_exp) begin
            timeout_pulse <= 1'b1;
            state         <= S_IDLE;
          end
        end
        S_EVAL: begin
          if (count_ok && buf_code == pw) begin
            fail_cnt <= '0;
            if (term_hash) begin
              open_pulse <= 1'b1;
              state      <= S_IDLE;
            end else begin
              change_mode <= 1'b1;
              timer       <= '0;
              state       <= S_NEW_A;
            end
          end else begin
            fail_pulse <= 1'b1;
            fail_cnt   <= fail_inc;
            if (fail_inc == FAIL_MAX) begin
              lockout  <= 1'b1;
              lock_cnt <= '0;
              state    <= S_LOCKOUT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_NEW_A, S_NEW_B: begin
          if (key_hash && count_ok && state == S_NEW_A) begin
            cand  <= buf_code;
            state <= S_NEW_B;
          end else if (key_hash && count_ok && buf_code == cand) begin
            pw          <= cand;
            pw_changed  <= 1'b1;
            change_mode <= 1'b0;
            state       <= S_IDLE;
          end else if (key_hash || key_star || timer_exp) begin
            err_pulse     <= 1'b1;
            timeout_pulse <= timer_exp;
            change_mode   <= 1'b0;
            state         <= S_IDLE;
          end
        end
        S_LOCKOUT: begin
          if (lock_cnt == LOCK_LAST) begin
            lockout  <= 1'b0;
            fail_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Bench for code_entry_ctrl: an entry-level model (digit queue, idle and
// lockout countdowns) is compared every cycle, plus directed literal checks.
module tb_code_entry_ctrl;

  localparam int DIGITS      = 4;
  localparam int TIMEOUT_CYC = 1000;
  localparam int MAX_FAIL    = 3;
  localparam int LOCKOUT_CYC = 5000;

  logic        clk, reset_1, key_valid;
  logic [3:0]  key_code;
  logic [15:0] code_word;
  logic [2:0]  digit_cnt;
  logic        open_pulse, fail_pulse, lockout, change_mode;
  logic        pw_changed, err_pulse, timeout_pulse;

  code_entry_ctrl dut (
    .clk           (clk),
    .reset_1       (reset_1),
    .key_code      (key_code),
    .key_valid     (key_valid),
    .code_word     (code_word),
    .digit_cnt     (digit_cnt),
    .open_pulse    (open_pulse),
    .fail_pulse    (fail_pulse),
    .lockout       (lockout),
    .change_mode   (change_mode),
    .pw_changed    (pw_changed),
    .err_pulse     (err_pulse),
    .timeout_pulse (timeout_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 no entry, 1 ordinary entry, 2 new password, 3 confirmation
  int          q[$];
  int          mode, idle_n, fails, lock_left;
  logic        judging, judge_hash;
  logic [15:0] m_pw, m_cand;
  logic        e_open, e_fail, e_pwc, e_err, e_to;

  function automatic logic [15:0] q_val();
    int v;
    v = 0;
    for (int i = 0; i < q.size() && i < DIGITS; i++) v = v * 16 + q[i];
    return 16'(v);
  endfunction

  always @(posedge clk or negedge reset_1) begin
    if (!reset_1) begin
      q.delete();
      mode = 0; idle_n = 0; fails = 0; lock_left = 0;
      judging = 1'b0; judge_hash = 1'b0;
      m_pw = 16'h1234; m_cand = 16'h0;
      e_open = 1'b0; e_fail = 1'b0; e_pwc = 1'b0; e_err = 1'b0; e_to = 1'b0;
    end else begin
      logic kd, kh, kt;
      kd = key_valid && key_code <= 4'd9;
      kh = key_valid && key_code == 4'hB;
      kt = kh || (key_valid && key_code == 4'hA);
      e_open = 1'b0; e_fail = 1'b0; e_pwc = 1'b0; e_err = 1'b0; e_to = 1'b0;
      if (judging) begin
        judging = 1'b0;
        if (q.size() == DIGITS && q_val() == m_pw) begin
          fails = 0;
          if (judge_hash) begin e_open = 1'b1; mode = 0; end
          else begin mode = 2; idle_n = 0; end
        end else begin
          e_fail = 1'b1;
          if (fails < MAX_FAIL) fails++;
          if (fails == MAX_FAIL) lock_left = LOCKOUT_CYC;
          mode = 0;
        end
        q.delete();
      end else if (lock_left > 0) begin
        lock_left--;
        if (lock_left == 0) fails = 0;
      end else if (mode == 0) begin
        if (kd) begin q.push_back(int'(key_code)); mode = 1; idle_n = 0; end
      end else if (kd) begin
        q.push_back(int'(key_code));
        idle_n = 0;
      end else if (kt) begin
        idle_n = 0;
        if (mode == 1) begin
          judging = 1'b1;
          judge_hash = kh;
        end else begin
          if (kh && q.size() == DIGITS && (mode == 2 || q_val() == m_cand)) begin
            if (mode == 2) begin m_cand = q_val(); mode = 3; end
            else begin m_pw = m_cand; e_pwc = 1'b1; mode = 0; end
          end else begin
            e_err = 1'b1;
            mode = 0;
          end
          q.delete();
        end
      end else if (idle_n == TIMEOUT_CYC - 1) begin
        e_to = 1'b1;
        e_err = (mode != 1);
        q.delete();
        mode = 0;
      end else begin
        idle_n++;
      end
    end
  end

  // ---------------- per-cycle compare and pulse counters ----------------
  int open_n = 0, fail_n = 0, pwc_n = 0, err_n = 0, to_n = 0;
  int lock_run = 0, lock_len = 0;

  always @(negedge clk) begin
    logic [2:0] e_cnt;
    e_cnt = (q.size() > DIGITS + 1) ? 3'(DIGITS + 1) : 3'(q.size());
    check("outputs",
          32'({code_word, digit_cnt, open_pulse, fail_pulse, lockout, change_mode,
               pw_changed, err_pulse, timeout_pulse}),
          32'({q_val(), e_cnt, e_open, e_fail, lock_left > 0, mode >= 2,
               e_pwc, e_err, e_to}));
    if (open_pulse) open_n++;
    if (fail_pulse) fail_n++;
    if (pw_changed) pwc_n++;
    if (err_pulse) err_n++;
    if (timeout_pulse) to_n++;
    if (lockout) lock_run++;
    else if (lock_run != 0) begin lock_len = lock_run; lock_run = 0; end
  end

  // ---------------- stimulus ----------------
  task automatic strobe(input logic [3:0] k);
    @(negedge clk);
    key_code = k;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    key_code = 4'h0;
  endtask

  // Keys packed as nibbles, first key in the most significant used nibble.
  task automatic enter(input logic [63:0] keys, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      strobe(keys[4*i +: 4]);
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_unlock();
    int i;
    i = 0;
    while (lockout && i < LOCKOUT_CYC + 50) begin
      @(negedge clk);
      i++;
    end
    check("lockout_ends", 32'(lockout), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int o0, f0, p0, e0, t0, lat;
    reset_1 = 1'b0;
    key_valid = 1'b0;
    key_code = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_code_word", 32'(code_word), 0);
    check("rst_digit_cnt", 32'(digit_cnt), 0);
    check("rst_flags", 32'({open_pulse, fail_pulse, lockout, change_mode,
                            pw_changed, err_pulse, timeout_pulse}), 0);
    #2 reset_1 = 1'b1;

    // Correct open, with an ignored 1100 code mid-entry
    enter(64'h12C34, 5);
    check("entry_code_word", 32'(code_word), 32'h1234);
    check("entry_digit_cnt", 32'(digit_cnt), 4);
    strobe(4'hB);
    check("eval_code_word", 32'(code_word), 32'h1234);
    check("eval_open_early", 32'(open_pulse), 0);
    @(negedge clk);
    check("open_pulse_n2", 32'(open_pulse), 1);
    check("open_clears_cnt", 32'(digit_cnt), 0);
    @(negedge clk);
    check("open_one_cycle", 32'(open_pulse), 0);
    repeat (3) @(negedge clk);

    // Three wrong entries lock out; keys during lockout are ignored
    o0 = open_n; f0 = fail_n;
    enter(64'h1235B, 5);
    enter(64'h1235B, 5);
    enter(64'h1235, 4);
    strobe(4'hB);
    check("lockout_not_yet", 32'(lockout), 0);
    @(negedge clk);
    check("lockout_asserts", 32'(lockout), 1);
    enter(64'h1234B, 5);
    wait_unlock();
    check("lockout_fail_pulses", fail_n - f0, 3);
    check("lockout_len", lock_len, LOCKOUT_CYC);
    check("lockout_no_open", open_n - o0, 0);

    // Password change to 9876
    p0 = pwc_n;
    enter(64'h1234A, 5);
    check("change_mode_on", 32'(change_mode), 1);
    enter(64'h9876B, 5);
    check("change_mode_confirm", 32'(change_mode), 1);
    enter(64'h9876, 4);
    strobe(4'hB);
    check("pw_changed_n1", 32'(pw_changed), 1);
    check("change_mode_off", 32'(change_mode), 0);
    repeat (3) @(negedge clk);
    o0 = open_n; f0 = fail_n;
    enter(64'h9876B, 5);
    enter(64'h1234B, 5);
    check("pw_changed_count", pwc_n - p0, 1);
    check("new_pw_opens", open_n - o0, 1);
    check("old_pw_fails", fail_n - f0, 1);

    // Reset mid-change restores the default password
    enter(64'h9876A, 5);
    enter(64'h55, 2);
    check("mid_change", 32'(change_mode), 1);
    @(negedge clk);
    #2 reset_1 = 1'b0;
    @(negedge clk);
    check("reset_change_mode", 32'(change_mode), 0);
    check("reset_digit_cnt", 32'(digit_cnt), 0);
    #2 reset_1 = 1'b1;
    repeat (2) @(negedge clk);

    // Mismatched confirmation aborts; default password still opens
    e0 = err_n; o0 = open_n;
    enter(64'h1234A, 5);
    enter(64'h5555B, 5);
    enter(64'h5556, 4);
    strobe(4'hB);
    check("err_pulse_n1", 32'(err_pulse), 1);
    repeat (3) @(negedge clk);
    enter(64'h1234B, 5);
    check("err_count", err_n - e0, 1);
    check("default_pw_opens", open_n - o0, 1);

    // Length errors fail; two fails plus one more locks out
    f0 = fail_n;
    enter(64'h123B, 4);
    enter(64'h12345B, 6);
    check("length_fails", fail_n - f0, 2);
    check("model_fail_count", fails, 2);
    enter(64'h1111, 4);
    strobe(4'hB);
    @(negedge clk);
    check("third_fail_locks", 32'(lockout), 1);
    wait_unlock();

    // Timeout discards the entry and does not count as a failure
    t0 = to_n;
    enter(64'h1235B, 5);
    strobe(4'h1);
    @(negedge clk);
    strobe(4'h2);
    lat = 1;
    while (!timeout_pulse && lat < TIMEOUT_CYC + 50) begin
      @(negedge clk);
      lat++;
    end
    check("timeout_latency", lat, TIMEOUT_CYC + 1);
    check("timeout_digit_cnt", 32'(digit_cnt), 0);
    repeat (3) @(negedge clk);
    enter(64'h1235, 4);
    strobe(4'hB);
    @(negedge clk);
    check("timeout_not_a_fail", 32'(lockout), 0);
    repeat (3) @(negedge clk);

    // A key on the expiry cycle extends the entry
    o0 = open_n;
    strobe(4'h1);
    @(negedge clk);
    strobe(4'h2);
    repeat (TIMEOUT_CYC - 2) @(negedge clk);
    strobe(4'h3);
    check("expiry_key_extends", 32'(digit_cnt), 3);
    enter(64'h4B, 2);
    check("expiry_timeouts", to_n - t0, 1);
    check("expiry_entry_opens", open_n - o0, 1);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/code_entry_ctrl.md
# code_entry_ctrl

Keypad entry sequencer and password manager for the lock. It consumes one-cycle key strobes from the keypad decoder and assembles digit sequences. It judges each sequence against the stored password and enforces a failed-attempt lockout. It also runs the two-entry password-change flow, and drives the open/fail/lockout indications that the lock state logic and display consume.

## Interface
- `DIGITS`, 4: digits per code; `code_word` width is 4*DIGITS.
- `TIMEOUT_CYC`, 1000: idle cycles between keys before an entry is discarded.
- `MAX_FAIL`, 3: consecutive failed evaluations that trigger lockout.
- `LOCKOUT_CYC`, 5000: lockout duration in cycles.
- `DEFAULT_PW`, 16'h1234: password after reset.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset_1` in 1: asynchronous, active-low reset.
- `key_code` in 4: 0000–1001 are digits 0–9, 1010 is `*`, 1011 is `#`, 1100–1111 are ignored.
- `key_valid` in 1: one-cycle strobe qualifying `key_code`.
- `code_word` out 16: current entry buffer, first digit in the MSB nibble, zero-filled.
- `digit_cnt` out 3: digits in buffer, saturating at DIGITS+1.
- `open_pulse` out 1: one cycle on a correct `#` entry.
- `fail_pulse` out 1: one cycle on a wrong entry.
- `lockout` out 1: high throughout LOCKOUT.
- `change_mode` out 1: high in NEW_A and NEW_B.
- `pw_changed` out 1: one cycle when a new password commits.
- `err_pulse` out 1: one cycle when the change flow aborts.
- `timeout_pulse` out 1: one cycle when an entry is discarded by timeout.

## Operation
- States: IDLE, COLLECT, EVAL, NEW_A, NEW_B, LOCKOUT.
- Reset values:
  - State is IDLE, `pw` is DEFAULT_PW, and the buffer, count, fail counter and timers are 0.
  - All outputs are 0.
- Digit handling:
  - A digit shifts the buffer left by one nibble and increments `digit_cnt`.
  - A digit arriving when the count is already DIGITS sets the overflow flag; the buffer is unchanged and the count moves to DIGITS+1.
- IDLE:
  - A digit loads the buffer and moves to COLLECT.
  - `*`, `#` and codes 1100–1111 are ignored.
- COLLECT:
  - A digit is shifted in.
  - A terminator (`#` or `*`) latches into `term` and moves to EVAL.
- EVAL lasts one cycle. `match` = (count==DIGITS) && !overflow && (buffer==pw).
  - `#` with match: `open_pulse`, fail counter cleared, go to IDLE.
  - `*` with match: fail counter cleared, go to NEW_A.
  - No match, either terminator: `fail_pulse` and fail counter +1. When the counter reaches MAX_FAIL, go to LOCKOUT; otherwise go to IDLE.
  - The buffer and count clear on leaving EVAL.
- NEW_A:
  - Digits are collected.
  - `#` with exactly DIGITS digits and no overflow: the buffer goes to `cand`, then NEW_B.
  - `#` with a bad count: `err_pulse`, go to IDLE.
  - `*`: `err_pulse`, go to IDLE.
- NEW_B:
  - Digits are collected.
  - `#` with buffer==cand and a valid count: `pw` <= cand, `pw_changed`, go to IDLE.
  - Any other `#`, or any `*`: `err_pulse`, go to IDLE.
- Timeout:
  - The timer runs in COLLECT, NEW_A and NEW_B, and reloads on every accepted key.
  - On reaching TIMEOUT_CYC-1 with no key: `timeout_pulse`, buffer cleared, go to IDLE, `pw` unchanged.
  - A timeout in NEW_A or NEW_B additionally raises `err_pulse`.
  - A timeout does not count as a failure.
- LOCKOUT:
  - All keys are ignored.
  - After LOCKOUT_CYC cycles, the fail counter clears and the state returns to IDLE.
- Boundary rules:
  - A key in the same cycle as timer expiry wins: it is processed and the timer reloads.
  - The fail counter saturates at MAX_FAIL.
  - Reset mid-entry or mid-change restores DEFAULT_PW and discards `cand`.

## Timing
- All outputs are registered.
- A key strobed in cycle N is reflected in `code_word`/`digit_cnt` in cycle N+1.
- A terminator in cycle N puts the FSM in EVAL in cycle N+1. `open_pulse`, `fail_pulse` and `lockout` assert in N+2.
- `pw_changed` and `err_pulse` assert in N+1 after the terminating key.
- Back-to-back keys are accepted every cycle, except the cycle the FSM sits in EVAL, where `key_valid` is dropped. The upstream keypad guarantees at least 2 cycles between strobes.
- `lockout` is high for exactly LOCKOUT_CYC cycles.

## Structure
- Shared package `lock_pkg`:
  - KEY_STAR (4'b1010) and KEY_HASH (4'b1011) constants.
  - `is_digit` function.
  - State encoding constants for this FSM.
- Sub-module `digit_buffer`: shift register, saturating count, overflow flag, with `clear` and `shift_en` inputs. It is shared by the COLLECT/NEW_A/NEW_B paths.
- The top level holds the FSM, `pw`/`cand` registers, fail counter, timeout counter and lockout counter.

## Test plan
- Correct open: keys 1,2,3,4,# after reset -> `open_pulse` for one cycle 2 cycles after `#`; `code_word` reads 16'h1234 before clearing.
- Lockout: three entries of 1,2,3,5,# -> three `fail_pulse`s; after the third, `lockout`=1 for LOCKOUT_CYC cycles; keys 1,2,3,4,# during lockout give no `open_pulse`.
- Password change: 1,2,3,4,\* then 9,8,7,6,# then 9,8,7,6,# -> `pw_changed`; then 9,8,7,6,# opens and 1,2,3,4,# fails.
- Mismatched confirm: 1,2,3,4,\*, 5,5,5,5,#, 5,5,5,6,# -> `err_pulse`; 1,2,3,4,# still opens.
- Length errors: 1,2,3,# and 1,2,3,4,5,# -> `fail_pulse` each; fail counter = 2.
- Timeout: 1,2 then TIMEOUT_CYC idle cycles -> `timeout_pulse`, `digit_cnt`=0, fail counter unchanged; a key on the expiry cycle instead extends the entry.
